console_arbiter: RTL and testbench
==================================

# console_arbiter

Line-granular arbiter sharing the single 7-bit console transmit stream between two requesters: port A (ZipCPU console transmit path) and port B (hexbus debug text output). It sits between the two producers and the console transmit sink, and grants ownership for a whole line so text from the two sources never interleaves mid-line. Ownership is released on a newline, on an owner idle timeout, or on a maximum line length. When both ports compete, arbitration is round-robin.

## Interface
- LGTIMEOUT, 10: log2 of owner-idle cycles before a grant is forcibly released.
- MAXLINE, 80: accepted bytes without newline before forced release; legal range 1..127.
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_a_stb  in  1  port A byte valid.
- i_a_data  in  7  port A byte.
- o_a_busy  out  1  port A stall.
- i_b_stb  in  1  port B byte valid.
- i_b_data  in  7  port B byte.
- o_b_busy  out  1  port B stall.
- o_console_stb  out  1  byte valid to sink.
- o_console_data  out  7  byte to sink.
- i_console_busy  in  1  sink stall.
- o_grant  out  2  one-hot owner {B,A}; 2'b00 when idle.

## Operation
- Handshake on every port: a byte transfers on a cycle where stb && !busy.
  - A producer holds stb and data stable while busy.
  - The arbiter never drops or duplicates a byte.
- States: IDLE, OWN_A, OWN_B. Register `last` records the most recently granted port.
- IDLE:
  - o_console_stb=0, o_a_busy=1, o_b_busy=1.
  - Only A strobing: go to OWN_A. Only B strobing: go to OWN_B.
  - Both strobing: grant the port not equal to `last`.
  - Neither strobing: stay in IDLE.
- OWN_x:
  - o_console_stb=i_x_stb, o_console_data=i_x_data, o_x_busy=i_console_busy.
  - The other port's busy is held at 1.
  - Path is combinational from the state register and inputs, so there is zero added latency while owned.
- Line counter (7 bits):
  - Cleared on entry to OWN_x.
  - Increments on each accepted byte.
- Idle counter (LGTIMEOUT+1 bits):
  - Cleared on entry to OWN_x and on every cycle i_x_stb=1.
  - Increments otherwise.
- Release to IDLE on the next edge when any of these holds:
  - The accepted byte is 7'h0a.
  - The accepted byte brings the line count to MAXLINE.
  - The idle counter reaches 2^LGTIMEOUT.
- Stalled owner: while i_x_stb=1 and i_console_busy=1, the owner is never timed out. The sink stall is not owner idleness.

## Timing
- Reset values:
  - State IDLE, `last`=B, so A wins the first tie.
  - Both counters 0.
  - o_console_stb=0, o_a_busy=1, o_b_busy=1, o_grant=2'b00.
  - o_console_data=7'h00.
- Grant latency:
  - Request visible in IDLE at cycle n: owner state at n+1; first transfer possible at n+1.
- Release:
  - Terminating byte accepted at cycle n: IDLE at n+1.
  - Earliest new grant is state at n+2; with both ports requesting, the other port is granted.
  - A port cannot retain the grant across a release while the other port is requesting.
- Timeout: owner stb low from cycle n onward gives IDLE at cycle n + 2^LGTIMEOUT.
- Reset mid-line:
  - IDLE after the reset edge.
  - A byte stalled at that moment is not consumed; its producer still sees busy=1.
- o_grant is a registered decode of the state and changes only on clock edges.

## Structure
- Shared package console_arb_pkg holds:
  - State enum {IDLE, OWN_A, OWN_B}.
  - Constant CONSOLE_NEWLINE = 7'h0a.
  - Port index constants PORT_A=0, PORT_B=1.
- Single module; no sub-module is warranted. Both counters and the FSM are inline.

## Test plan
- A alone sends "hi\n" with sink never busy:
  - o_grant=01 one cycle after the first strobe.
  - Three transfers 7'h68, 7'h69, 7'h0a on consecutive cycles.
  - o_grant=00 the cycle after 7'h0a.
- A and B both strobe from reset, both lines ending in 7'h0a:
  - A granted first; B held busy the entire time.
  - B granted two cycles after A's newline; output shows no interleaving.
- B owns and the sink asserts i_console_busy for 3000 cycles with i_b_stb held:
  - No timeout release.
  - The byte transfers once busy drops.
- A sends 'x', then stb low, with LGTIMEOUT=4:
  - Grant released exactly 16 cycles later.
  - A waiting B is granted on the following cycle.
- A streams 100 non-newline bytes with MAXLINE=80 while B requests:
  - Release after the 80th accepted byte.
  - B granted; A's 81st byte held with o_a_busy=1.
- i_rst pulsed while A owns with a byte stalled:
  - Next cycle o_grant=00 and both busies=1.
  - The stalled byte is transferred after a fresh grant, exactly once.

Source files
------------

// File: rtl/console_arb_pkg.sv
// Shared types and constants for the line-granular console arbiter.
package console_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam logic [6:0] CONSOLE_NEWLINE = 7'h0a;
    localparam logic       PORT_A          = 1'b0;
    localparam logic       PORT_B          = 1'b1;

endpackage

// File: rtl/console_arbiter.sv
// Shares one 7-bit console transmit stream between two producers, granting a whole
// line at a time; released on newline, MAXLINE bytes, or owner idle timeout.
module console_arbiter
    import console_arb_pkg::*;
#(
    parameter int LGTIMEOUT = 10,
    parameter int MAXLINE   = 80
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a_stb,
    input  logic [6:0] i_a_data,
    output logic       o_a_busy,
    input  logic       i_b_stb,
    input  logic [6:0] i_b_data,
    output logic       o_b_busy,
    output logic       o_console_stb,
    output logic [6:0] o_console_data,
    input  logic       i_console_busy,
    output logic [1:0] o_grant
);

    localparam int            IW         = LGTIMEOUT + 1;
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(2 ** LGTIMEOUT);
    localparam logic [7:0]    LINE_LIMIT = 8'(MAXLINE);

    arb_state_t    state_q, state_d;
    logic          last_q, last_d;
    logic [6:0]    line_cnt_q, line_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]    grant_q, grant_d;

    logic          own_stb;
    logic [6:0]    own_data;
    logic          accept;
    logic          line_done;
    logic          timed_out;

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        line_cnt_d     = line_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        own_stb        = 1'b0;
        own_data       = 7'h00;
        accept         = 1'b0;
        line_done      = 1'b0;
        timed_out      = 1'b0;
        o_console_stb  = 1'b0;
        o_console_data = 7'h00;
        o_a_busy       = 1'b1;
        o_b_busy       = 1'b1;

        case (state_q)
            IDLE: begin
                line_cnt_d = 7'd0;
                idle_cnt_d = '0;
                // On a tie the port that did not own last time wins.
                if (i_a_stb && (!i_b_stb || last_q == PORT_B)) begin
                    state_d = OWN_A;
                    last_d  = PORT_A;
                end else if (i_b_stb) begin
                    state_d = OWN_B;
                    last_d  = PORT_B;
                end
            end
            OWN_A: begin
                own_stb  = i_a_stb;
                own_data = i_a_data;
                o_a_busy = i_console_busy;
            end
            OWN_B: begin
                own_stb  = i_b_stb;
                own_data = i_b_data;
                o_b_busy = i_console_busy;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == OWN_A || state_q == OWN_B) begin
            o_console_stb  = own_stb;
            o_console_data = own_data;
            accept         = own_stb && !i_console_busy;
            line_cnt_d     = line_cnt_q + 7'(accept);
            // A strobing owner stalled by the sink is still active, so only a low
            // strobe counts toward the idle timeout.
            idle_cnt_d     = own_stb ? '0 : idle_cnt_q + 1'b1;
            line_done      = accept && (own_data == CONSOLE_NEWLINE ||
                                        ({1'b0, line_cnt_q} + 8'd1) == LINE_LIMIT);
            timed_out      = !own_stb && (idle_cnt_q + 1'b1) == IDLE_LIMIT;
            if (line_done || timed_out) begin
                state_d = IDLE;
            end
        end

        case (state_d)
            OWN_A:   grant_d = 2'b01;
            OWN_B:   grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            last_q     <= PORT_B;
            line_cnt_q <= 7'd0;
            idle_cnt_q <= '0;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            line_cnt_q <= line_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            grant_q    <= grant_d;
        end
    end

    assign o_grant = grant_q;

endmodule

// File: tb/tb_console_arbiter.sv
// Randomized self-checking bench for console_arbiter against a line-ownership model.
module tb_console_arbiter;

    localparam int LGT  = 4;
    localparam int MAXL = 80;
    localparam int TLIM = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_stb, b_stb, sink_busy;
    logic [6:0] a_data, b_data;
    logic       a_busy, b_busy, con_stb;
    logic [6:0] con_data;
    logic [1:0] grant;

    always #5 clk = ~clk;

    console_arbiter #(.LGTIMEOUT(LGT), .MAXLINE(MAXL)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_stb(a_stb), .i_a_data(a_data), .o_a_busy(a_busy),
        .i_b_stb(b_stb), .i_b_data(b_data), .o_b_busy(b_busy),
        .o_console_stb(con_stb), .o_console_data(con_data),
        .i_console_busy(sink_busy), .o_grant(grant)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: which port owns the line (0 none, 1 A, 2 B), who owned last,
    // bytes in the current line and consecutive silent cycles of the owner.
    int m_owner, m_last, m_cnt, m_silent;
    logic [6:0] q_a[$], q_b[$];
    logic [6:0] out_log[$];
    int         out_cyc[$];
    int a_pct, b_pct, busy_mode, busy_pct, cyc;
    bit chk_en;

    task automatic cycle();
        logic       own_stb, acc, acc_a, acc_b;
        logic [6:0] own_data;
        @(negedge clk);
        own_stb  = 1'b0;
        own_data = 7'h00;
        if (m_owner == 1) begin own_stb = a_stb; own_data = a_data; end
        if (m_owner == 2) begin own_stb = b_stb; own_data = b_data; end
        if (chk_en) begin
            check("grant", grant, (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
            check("con_stb", con_stb, own_stb);
            check("con_data", con_data, own_data);
            check("a_busy", a_busy, (m_owner == 1) ? sink_busy : 1'b1);
            check("b_busy", b_busy, (m_owner == 2) ? sink_busy : 1'b1);
        end
        acc   = own_stb && !sink_busy;
        acc_a = acc && m_owner == 1;
        acc_b = acc && m_owner == 2;
        if (acc_a) begin
            check("sb_a_avail", q_a.size() > 0, 1);
            if (q_a.size() > 0) check("sb_a", con_data, q_a[0]);
        end
        if (acc_b) begin
            check("sb_b_avail", q_b.size() > 0, 1);
            if (q_b.size() > 0) check("sb_b", con_data, q_b[0]);
        end
        if (acc) begin
            out_log.push_back(own_data);
            out_cyc.push_back(cyc);
        end
        if (rst) begin
            m_owner = 0; m_last = 2; m_cnt = 0; m_silent = 0;
        end else if (m_owner == 0) begin
            m_cnt = 0; m_silent = 0;
            if (a_stb && b_stb) m_owner = (m_last == 1) ? 2 : 1;
            else if (a_stb)     m_owner = 1;
            else if (b_stb)     m_owner = 2;
            if (m_owner != 0) m_last = m_owner;
        end else begin
            if (acc) m_cnt++;
            m_silent = own_stb ? 0 : m_silent + 1;
            if ((acc && (own_data == 7'h0a || m_cnt == MAXL)) || m_silent == TLIM) m_owner = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc_a) void'(q_a.pop_front());
        if (acc_b) void'(q_b.pop_front());
        if (!(a_stb && !acc_a)) begin
            a_stb  = (q_a.size() > 0) && (int'($urandom_range(99)) < a_pct);
            a_data = a_stb ? q_a[0] : 7'($urandom);
        end
        if (!(b_stb && !acc_b)) begin
            b_stb  = (q_b.size() > 0) && (int'($urandom_range(99)) < b_pct);
            b_data = b_stb ? q_b[0] : 7'($urandom);
        end
        case (busy_mode)
            0:       sink_busy = int'($urandom_range(99)) < busy_pct;
            1:       sink_busy = 1'b1;
            default: sink_busy = 1'b0;
        endcase
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_a.size() > 0 || q_b.size() > 0 || m_owner != 0 || a_stb || b_stb) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_in_budget", n < budget, 1);
    endtask

    task automatic push_str(input int port, input string s);
        logic [6:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = 7'(s[i]);
            if (port == 1) q_a.push_back(c); else q_b.push_back(c);
        end
    endtask

    initial begin
        int n0, rel, gb, n, len;
        rst = 1'b1; a_stb = 0; b_stb = 0; a_data = 0; b_data = 0; sink_busy = 0;
        a_pct = 100; b_pct = 100; busy_mode = 2; busy_pct = 30; cyc = 0; chk_en = 0;
        m_owner = 0; m_last = 2; m_cnt = 0; m_silent = 0;
        cycle();
        chk_en = 1;
        cycle();
        rst = 1'b0;

        // "hi\n" from A alone with an always-ready sink
        out_log.delete(); out_cyc.delete();
        push_str(1, "hi\n");
        drain(30);
        check("hi_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("hi_b0", out_log[0], 7'h68);
            check("hi_b1", out_log[1], 7'h69);
            check("hi_b2", out_log[2], 7'h0a);
            check("hi_consec1", out_cyc[1] - out_cyc[0], 1);
            check("hi_consec2", out_cyc[2] - out_cyc[0], 2);
        end

        // Both ports from reset: A first, B two cycles after A's newline
        rst = 1'b1; cycle(); rst = 1'b0;
        out_log.delete(); out_cyc.delete();
        push_str(1, "AAA\n");
        push_str(2, "BB\n");
        drain(60);
        check("tie_count", out_log.size(), 7);
        if (out_log.size() == 7) begin
            check("tie_a_first", out_log[0], 7'h41);
            check("tie_a_nl", out_log[3], 7'h0a);
            check("tie_b_first", out_log[4], 7'h42);
            check("tie_b_gap", out_cyc[4] - out_cyc[3], 2);
        end

        // B owns while the sink stalls far longer than the idle timeout
        out_log.delete(); out_cyc.delete();
        busy_mode = 1;
        push_str(2, "Z\n");
        for (int i = 0; i < 3000; i++) cycle();
        check("stall_grant", grant, 2'b10);
        check("stall_no_xfer", out_log.size(), 0);
        busy_mode = 2;
        drain(40);
        check("stall_count", out_log.size(), 2);
        if (out_log.size() > 0) check("stall_byte", out_log[0], 7'h5a);

        // Owner idle timeout, then a waiting B takes over
        out_log.delete(); out_cyc.delete();
        push_str(1, "x");
        n = 0;
        while (out_log.size() == 0 && n < 40) begin cycle(); n++; end
        check("to_x_sent", out_log.size(), 1);
        n0 = (out_log.size() > 0) ? out_cyc[0] : 0;
        push_str(2, "y\n");
        rel = -1; gb = -1; n = 0;
        while (gb < 0 && n < 80) begin
            cycle(); n++;
            if (grant == 2'b00 && rel < 0) rel = cyc;
            if (grant == 2'b10) gb = cyc;
        end
        check("to_release", rel - (n0 + 1), TLIM);
        check("to_b_grant", gb - rel, 1);
        drain(60);

        // MAXLINE forced release while B is waiting
        out_log.delete(); out_cyc.delete();
        for (int i = 0; i < 100; i++) q_a.push_back(7'h61);
        for (int i = 0; i < 4; i++) cycle();
        push_str(2, "b\n");
        drain(600);
        check("max_count", out_log.size(), 102);
        if (out_log.size() == 102) begin
            check("max_b79", out_log[79], 7'h61);
            check("max_b80", out_log[80], 7'h62);
            check("max_b81", out_log[81], 7'h0a);
            check("max_b82", out_log[82], 7'h61);
        end

        // Reset while A owns with a stalled byte
        out_log.delete(); out_cyc.delete();
        busy_mode = 1;
        push_str(1, "r\n");
        for (int i = 0; i < 4; i++) cycle();
        check("rst_owned", grant, 2'b01);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("rst_grant", grant, 2'b00);
        check("rst_a_busy", a_busy, 1'b1);
        check("rst_b_busy", b_busy, 1'b1);
        check("rst_held", a_stb, 1'b1);
        busy_mode = 2;
        drain(60);
        check("rst_count", out_log.size(), 2);
        if (out_log.size() > 0) check("rst_byte", out_log[0], 7'h72);

        // Randomized contention with a random sink
        busy_mode = 0;
        for (int r = 0; r < 4; r++) begin
            a_pct = 30 + int'($urandom_range(70));
            b_pct = 30 + int'($urandom_range(70));
            busy_pct = int'($urandom_range(50));
            for (int l = 0; l < 3; l++) begin
                len = 1 + int'($urandom_range(89));
                for (int k = 0; k < len; k++) q_a.push_back(7'($urandom));
                q_a.push_back(7'h0a);
                len = 1 + int'($urandom_range(89));
                for (int k = 0; k < len; k++) q_b.push_back(7'($urandom));
                q_b.push_back(7'h0a);
            end
            drain(8000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
